// File: rtl/alu_pkg.sv
// Shared types for the ALU result capture stage: display FSM states, captured result layout,
// and the padding used when the flags are shown on the 4-bit display.
package alu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShowF,
        StShowFlags
    } disp_state_e;

    typedef struct packed {
        logic       cn4;
        logic       equal;
        logic [3:0] f;
    } alu_result_t;

    localparam logic [1:0] FlagPad = 2'b00;

endpackage

// File: rtl/alu_result_capture_if.sv
// Valid/ready capture port carrying one 74181 result {cn4, equal, f}.
interface alu_result_capture_if;

    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_f;
    logic       in_cn4;
    logic       in_equal;

    modport master (output in_valid, in_f, in_cn4, in_equal, input in_ready);
    modport slave  (input in_valid, in_f, in_cn4, in_equal, output in_ready);

endinterface

// File: rtl/alu_result_fifo.sv
// Result FIFO: storage, pointers, occupancy and status.
// ALU_CAPTURE_OVERWRITE_EN: always accept, dropping the oldest entry when full (sticky overflow).
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_req,
    input  alu_result_t                  wdata,
    output logic                         push_ready,
    input  logic                         pop_req,
    output logic                         pop_fire,
    output alu_result_t                  head_next,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   count_next,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    alu_result_t       mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_fire, drop;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
`ifdef ALU_CAPTURE_OVERWRITE_EN
        push_ready = 1'b1;
`else
        push_ready = !full;
`endif
        pop_fire  = pop_req && !empty;
        push_fire = push_req && push_ready;
        // Push into a full FIFO without a pop evicts the head.
        drop      = push_fire && full && !pop_fire;

        head_d  = head_q + PW'(pop_fire || drop);
        tail_d  = tail_q + PW'(push_fire);
        count_d = count_q;
        if (push_fire && !pop_fire && !full) begin
            count_d = count_q + CW'(1);
        end else if (pop_fire && !push_fire) begin
            count_d = count_q - CW'(1);
        end
`ifdef ALU_CAPTURE_OVERWRITE_EN
        overflow_d = overflow_q || drop;
`else
        overflow_d = 1'b0;
`endif
        // The slot being written becomes the head only when nothing else remains ahead of it.
        head_next = (push_fire && (head_d == tail_q)) ? wdata : mem_q[head_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_fire) begin
            mem_q[tail_q] <= wdata;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign overflow   = overflow_q;

endmodule

// File: rtl/alu_result_capture.sv
// ALU result capture: FIFO of results shown on a 7-seg digit, alternating value and flags phases.
// ALU_CAPTURE_OVERWRITE_EN selects overwrite-oldest behaviour in the FIFO.
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DWELL = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_result_capture_if.slave        up,
    input  logic                       pop,
    output logic [3:0]                 disp_nibble,
    output logic                       disp_dp,
    output logic                       disp_blank,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = $clog2(DWELL);

    disp_state_e   state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    nibble_d;
    logic          pop_fire;
    logic [CW-1:0] count_next;
    alu_result_t   head_next;
    alu_result_t   wdata;

    assign wdata = '{cn4: up.in_cn4, equal: up.in_equal, f: up.in_f};

    alu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_req   (up.in_valid),
        .wdata      (wdata),
        .push_ready (up.in_ready),
        .pop_req    (pop),
        .pop_fire   (pop_fire),
        .head_next  (head_next),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        if (pop_fire) begin
            dwell_d = '0;
            state_d = (count_next == '0) ? StIdle : StShowF;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count != '0) begin
                        state_d = StShowF;
                        dwell_d = '0;
                    end
                end
                StShowF, StShowFlags: begin
                    if (dwell_q == DW'(DWELL - 1)) begin
                        dwell_d = '0;
                        state_d = (state_q == StShowF) ? StShowFlags : StShowF;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        unique case (state_d)
            StShowF:     nibble_d = head_next.f;
            StShowFlags: nibble_d = {FlagPad, head_next.cn4, head_next.equal};
            default:     nibble_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dwell_q     <= '0;
            disp_nibble <= 4'h0;
            disp_dp     <= 1'b0;
            disp_blank  <= 1'b1;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            disp_nibble <= nibble_d;
            disp_dp     <= (state_d == StShowFlags);
            disp_blank  <= (state_d == StIdle);
        end
    end

endmodule

// File: tb/tb_alu_result_capture.sv
// Bench for alu_result_capture: directed scenarios then random traffic against a queue model.
module tb_alu_result_capture;
    import alu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DWELL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pop = 1'b0;
    logic [3:0] disp_nibble;
    logic       disp_dp, disp_blank, full, empty, overflow;
    logic [2:0] count;

    always #5 clk = ~clk;

    alu_result_capture_if bus ();

    alu_result_capture #(
        .DEPTH (DEPTH),
        .DWELL (DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .up          (bus.slave),
        .pop         (pop),
        .disp_nibble (disp_nibble),
        .disp_dp     (disp_dp),
        .disp_blank  (disp_blank),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of held results, display phase (0 blank, 1 value, 2 flags).
    alu_result_t q[$];
    int          phase = 0;
    int          dwell = 0;
    bit          ovf = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_update(input bit r, input bit v, input alu_result_t d,
                                         input bit p);
        int  n;
        bit  pop_ok, push_ok;
        n = q.size();
        if (r) begin
            q.delete();
            phase = 0;
            dwell = 0;
            ovf   = 1'b0;
            return;
        end
        pop_ok = p && (n > 0);
`ifdef ALU_CAPTURE_OVERWRITE_EN
        push_ok = v;
        if (push_ok && n == DEPTH && !pop_ok) begin
            void'(q.pop_front());
            ovf = 1'b1;
        end
`else
        push_ok = v && (n != DEPTH);
`endif
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(d);
        if (pop_ok) begin
            phase = (q.size() == 0) ? 0 : 1;
            dwell = 0;
        end else if (phase == 0) begin
            if (n != 0) begin
                phase = 1;
                dwell = 0;
            end
        end else if (dwell == DWELL - 1) begin
            phase = (phase == 1) ? 2 : 1;
            dwell = 0;
        end else begin
            dwell++;
        end
    endfunction

    task automatic check_all();
        logic [3:0] exp_nib;
        bit         exp_ready;
        exp_nib = 4'h0;
        if (phase == 1) exp_nib = q[0].f;
        if (phase == 2) exp_nib = {2'b00, q[0].cn4, q[0].equal};
`ifdef ALU_CAPTURE_OVERWRITE_EN
        exp_ready = 1'b1;
`else
        exp_ready = (q.size() != DEPTH);
`endif
        check("count",    8'(count),       8'(q.size()));
        check("full",     8'(full),        8'(q.size() == DEPTH));
        check("empty",    8'(empty),       8'(q.size() == 0));
        check("in_ready", 8'(bus.in_ready), 8'(exp_ready));
        check("overflow", 8'(overflow),    8'(ovf));
        check("blank",    8'(disp_blank),  8'(phase == 0));
        check("dp",       8'(disp_dp),     8'(phase == 2));
        check("nibble",   8'(disp_nibble), 8'(exp_nib));
    endtask

    task automatic step(input bit r, input bit v, input alu_result_t d, input bit p);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.in_cn4   = d.cn4;
        bus.in_equal = d.equal;
        bus.in_f     = d.f;
        pop          = p;
        @(posedge clk);
        model_update(r, v, d, p);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic [3:0] f);
        step(1'b0, 1'b1, '{cn4: f[0], equal: f[1], f: f}, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_f     = 4'h0;
        bus.in_cn4   = 1'b0;
        bus.in_equal = 1'b0;

        // 1: reset / idle
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, '{cn4: 1'b1, equal: 1'b1, f: 4'hF}, 1'b0);
        idle(1);
        check("t1_blank", 8'(disp_blank), 8'h01);
        check("t1_count", 8'(count), 8'h00);

        // 2: single entry, alternating phases
        step(1'b0, 1'b1, '{cn4: 1'b1, equal: 1'b0, f: 4'hA}, 1'b0);
        idle(1);
        check("t2_value", 8'(disp_nibble), 8'h0A);
        idle(DWELL);
        check("t2_flags", {3'b0, disp_dp, disp_nibble}, 8'h12);
        idle(DWELL);
        check("t2_back", {3'b0, disp_dp, disp_nibble}, 8'h0A);
        step(1'b0, 1'b0, '0, 1'b1);

        // 3: fill, overfill attempt, drain, extra pop
        for (int i = 1; i <= 4; i++) push(4'(i));
        push(4'h9);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            idle(1);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        check("t3_count", 8'(count), 8'h00);

        // 4: simultaneous push and pop with two held
        push(4'h6);
        push(4'h7);
        idle(DWELL + 2);
        step(1'b0, 1'b1, '{cn4: 1'b0, equal: 1'b1, f: 4'h8}, 1'b1);
        check("t4_count", 8'(count), 8'h02);
        check("t4_value", {3'b0, disp_dp, disp_nibble}, 8'h07);
        idle(DWELL - 1);
        check("t4_dwell", 8'(disp_dp), 8'h00);
        step(1'b1, 1'b0, '0, 1'b0);

`ifdef ALU_CAPTURE_OVERWRITE_EN
        // 5: overwrite oldest when full
        for (int i = 1; i <= 5; i++) push(4'(i));
        idle(1);
        check("t5_ovf", 8'(overflow), 8'h01);
        check("t5_head", 8'(disp_nibble), 8'h02);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        check("t5_sticky", 8'(overflow), 8'h01);
        step(1'b1, 1'b0, '0, 1'b0);
`endif

        // 6: reset mid-dwell with three held
        push(4'h3);
        push(4'h4);
        push(4'h5);
        idle(2);
        step(1'b1, 1'b1, '{cn4: 1'b1, equal: 1'b0, f: 4'hC}, 1'b0);
        check("t6_blank", 8'(disp_blank), 8'h01);
        check("t6_count", 8'(count), 8'h00);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 79) == 0, 1'(($urandom_range(0, 2) != 0)),
                 alu_result_t'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
